zoom_pixel_engine: RTL

Datapath stage directly downstream of the zoom controller. It consumes the controller's `ALGORITHM` and `IMAGE_STATE` outputs and, on a start pulse, walks the source image in on-chip memory. For each destination pixel it reads the required source pixels and writes the result into the output frame buffer. It supports four modes: 1:1 copy, 2x enlarge (nearest neighbour or pixel replication) and 1/2 reduce (decimation or block averaging).

---
 rtl/zoom_pixel_engine_if.sv | 33 +++
 rtl/zoom_pixel_engine.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/zoom_pixel_engine_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | zoom_pixel_engine_if : control, source-read and destination-write bundle   |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface zoom_pixel_engine_if #(
  parameter int SRC_AW = 15,
  parameter int DST_AW = 17
);
  logic              START;
  logic [1:0]        ALGORITHM;
  logic [1:0]        IMAGE_STATE;
  logic [SRC_AW-1:0] SRC_ADDR;
  logic              SRC_RD;
  logic [7:0]        SRC_DATA;
  logic [DST_AW-1:0] DST_ADDR;
  logic [7:0]        DST_DATA;
  logic              DST_WE;
  logic              BUSY;
  logic              DONE;

  // The master side owns the control inputs and the source memory read port.
  modport master (
    output START, ALGORITHM, IMAGE_STATE, SRC_DATA,
    input  SRC_ADDR, SRC_RD, DST_ADDR, DST_DATA, DST_WE, BUSY, DONE
  );

  modport slave (
    input  START, ALGORITHM, IMAGE_STATE, SRC_DATA,
    output SRC_ADDR, SRC_RD, DST_ADDR, DST_DATA, DST_WE, BUSY, DONE
  );
endinterface
`default_nettype wire

// File: rtl/zoom_pixel_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | zoom_pixel_engine : copy / 2x enlarge / 1/2 reduce of an 8-bit frame       |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module zoom_pixel_engine #(
  parameter int SRC_W  = 160,
  parameter int SRC_H  = 120,
  parameter int SRC_AW = 15,
  parameter int DST_AW = 17
) (
  input  logic               CLK,
  input  logic               RESET,
  zoom_pixel_engine_if.slave bus
);
  localparam int CXW = $clog2(2*SRC_W);
  localparam int CYW = $clog2(2*SRC_H);

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_RD   = 4'd1;
  localparam logic [3:0] ST_RD1  = 4'd2;
  localparam logic [3:0] ST_RD2  = 4'd3;
  localparam logic [3:0] ST_RD3  = 4'd4;
  localparam logic [3:0] ST_WR   = 4'd5;
  localparam logic [3:0] ST_WR1  = 4'd6;
  localparam logic [3:0] ST_WR2  = 4'd7;
  localparam logic [3:0] ST_WR3  = 4'd8;
  localparam logic [3:0] ST_FIN  = 4'd9;

  localparam logic [2:0] MODE_COPY = 3'd0;
  localparam logic [2:0] MODE_NN   = 3'd1;
  localparam logic [2:0] MODE_PR   = 3'd2;
  localparam logic [2:0] MODE_DC   = 3'd3;
  localparam logic [2:0] MODE_BA   = 3'd4;

  logic [3:0]        state_q, state_d;
  logic [2:0]        mode_q, mode_d;
  logic [CXW-1:0]    x_q, x_d;
  logic [CYW-1:0]    y_q, y_d;
  logic [SRC_AW-1:0] srow_q, srow_d;
  logic [DST_AW-1:0] drow_q, drow_d;
  logic [9:0]        acc_q, acc_d;
  logic [7:0]        pix_q, pix_d;

  logic [CXW-1:0]    x_last;
  logic [CYW-1:0]    y_last;
  logic [SRC_AW-1:0] srow_step, src_base, src_addr;
  logic [DST_AW-1:0] drow_step, dst_base, dst_addr;
  logic [9:0]        ba_sum;
  logic [7:0]        wr_data;
  logic [2:0]        start_mode;
  logic              unit_end, rd_en, we_en;
  logic              unused_alg;

  assign unused_alg = bus.ALGORITHM[1];

  always_comb begin
    start_mode = MODE_COPY;
    if (bus.IMAGE_STATE == 2'd1)
      start_mode = bus.ALGORITHM[0] ? MODE_PR : MODE_NN;
    else if (bus.IMAGE_STATE == 2'd2)
      start_mode = bus.ALGORITHM[0] ? MODE_BA : MODE_DC;
  end

  // x/y walk the unit grid of the active mode: destination pixels, except PR
  // which walks source pixels and emits a 2x2 block per unit.
  always_comb begin
    x_last    = CXW'(SRC_W-1);
    y_last    = CYW'(SRC_H-1);
    srow_step = SRC_AW'(SRC_W);
    drow_step = DST_AW'(SRC_W);
    src_base  = srow_q + SRC_AW'(x_q);
    dst_base  = drow_q + DST_AW'(x_q);
    case (mode_q)
      MODE_NN: begin
        x_last    = CXW'(2*SRC_W-1);
        y_last    = CYW'(2*SRC_H-1);
        srow_step = y_q[0] ? SRC_AW'(SRC_W) : '0;
        drow_step = DST_AW'(2*SRC_W);
        src_base  = srow_q + SRC_AW'(x_q >> 1);
      end
      MODE_PR: begin
        drow_step = DST_AW'(4*SRC_W);
        dst_base  = drow_q + DST_AW'({x_q, 1'b0});
      end
      MODE_DC, MODE_BA: begin
        x_last    = CXW'(SRC_W/2-1);
        y_last    = CYW'(SRC_H/2-1);
        srow_step = SRC_AW'(2*SRC_W);
        drow_step = DST_AW'(SRC_W/2);
        src_base  = srow_q + SRC_AW'({x_q, 1'b0});
      end
      default: ;
    endcase
  end

  always_comb begin
    case (state_q)
      ST_RD1:  src_addr = src_base + SRC_AW'(1);
      ST_RD2:  src_addr = src_base + SRC_AW'(SRC_W);
      ST_RD3:  src_addr = src_base + SRC_AW'(SRC_W+1);
      default: src_addr = src_base;
    endcase
    case (state_q)
      ST_WR1:  dst_addr = dst_base + DST_AW'(1);
      ST_WR2:  dst_addr = dst_base + DST_AW'(2*SRC_W);
      ST_WR3:  dst_addr = dst_base + DST_AW'(2*SRC_W+1);
      default: dst_addr = dst_base;
    endcase
  end

  // Three block samples are already in acc_q; the fourth arrives this cycle.
  assign ba_sum  = acc_q + 10'(bus.SRC_DATA) + 10'd2;
  assign wr_data = (state_q != ST_WR)   ? pix_q :
                   (mode_q == MODE_BA)  ? 8'(ba_sum >> 2) : bus.SRC_DATA;

  assign rd_en = (state_q >= ST_RD) && (state_q <= ST_RD3);
  assign we_en = (state_q >= ST_WR) && (state_q <= ST_WR3);

  assign bus.SRC_RD   = rd_en;
  assign bus.SRC_ADDR = rd_en ? src_addr : '0;
  assign bus.DST_WE   = we_en;
  assign bus.DST_ADDR = we_en ? dst_addr : '0;
  assign bus.DST_DATA = we_en ? wr_data : '0;
  assign bus.BUSY     = rd_en | we_en;
  assign bus.DONE     = (state_q == ST_FIN);

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    x_d      = x_q;
    y_d      = y_q;
    srow_d   = srow_q;
    drow_d   = drow_q;
    acc_d    = acc_q;
    pix_d    = pix_q;
    unit_end = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.START) begin
          state_d = ST_RD;
          mode_d  = start_mode;
          x_d     = '0;
          y_d     = '0;
          srow_d  = '0;
          drow_d  = '0;
          acc_d   = '0;
        end
      end
      ST_RD: begin
        acc_d   = '0;
        state_d = (mode_q == MODE_BA) ? ST_RD1 : ST_WR;
      end
      ST_RD1: begin
        acc_d   = acc_q + 10'(bus.SRC_DATA);
        state_d = ST_RD2;
      end
      ST_RD2: begin
        acc_d   = acc_q + 10'(bus.SRC_DATA);
        state_d = ST_RD3;
      end
      ST_RD3: begin
        acc_d   = acc_q + 10'(bus.SRC_DATA);
        state_d = ST_WR;
      end
      ST_WR: begin
        pix_d = bus.SRC_DATA;
        if (mode_q == MODE_PR)
          state_d = ST_WR1;
        else
          unit_end = 1'b1;
      end
      ST_WR1: state_d = ST_WR2;
      ST_WR2: state_d = ST_WR3;
      ST_WR3: unit_end = 1'b1;
      ST_FIN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (unit_end) begin
      if (x_q == x_last) begin
        x_d = '0;
        if (y_q == y_last) begin
          state_d = ST_FIN;
        end else begin
          y_d     = y_q + 1'b1;
          srow_d  = srow_q + srow_step;
          drow_d  = drow_q + drow_step;
          state_d = ST_RD;
        end
      end else begin
        x_d     = x_q + 1'b1;
        state_d = ST_RD;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_COPY;
      x_q     <= '0;
      y_q     <= '0;
      srow_q  <= '0;
      drow_q  <= '0;
      acc_q   <= '0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      y_q     <= y_d;
      srow_q  <= srow_d;
      drow_q  <= drow_d;
      acc_q   <= acc_d;
      pix_q   <= pix_d;
    end
  end
endmodule
`default_nettype wire
